// File: rtl/multicycle_control_unit.sv
// Control unit for the multicycle ARM-subset datapath: Moore main FSM, ALU
// decoder, NZCV flag register and condition result registered at DECODE.
module multicycle_control_unit #(
    parameter int ALUCTRL_W   = 4,
    parameter bit HAS_NOWRITE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:12]         Instr,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condexr_q, condexr_d;

    logic [1:0] op_s;
    logic [5:0] funct_s;
    logic [3:0] cmd_s, rd_s, cond_s;
    logic       next_pc_s, branch_s, regw_s, memw_s, alu_op_s, ir_s;
    logic [2:0] alu_code_s;
    logic       supported_s, arith_s, is_cmp_s, nowrite_s;
    logic [1:0] flag_w_s;
    logic       condex_s, pcs_s, wb_state_s;
    logic       flag_n_s, flag_z_s, flag_c_s, flag_v_s;
    logic       unused_rn_s;

    assign op_s        = Instr[27:26];
    assign funct_s     = Instr[25:20];
    assign cmd_s       = funct_s[4:1];
    assign rd_s        = Instr[15:12];
    assign cond_s      = Instr[31:28];
    assign unused_rn_s = ^Instr[19:16];
    assign {flag_n_s, flag_z_s, flag_c_s, flag_v_s} = flags_q;

    // Next-state logic of the main FSM
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = funct_s[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:               state_d = funct_s[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:              state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
            default:                state_d = S_FETCH;
        endcase
    end

    // Moore per-state controls and datapath selects
    always_comb begin
        next_pc_s = 1'b0;
        branch_s  = 1'b0;
        regw_s    = 1'b0;
        memw_s    = 1'b0;
        alu_op_s  = 1'b0;
        ir_s      = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_s = 1'b1; next_pc_s = 1'b1;
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB:    begin ResultSrc = 2'b01; regw_s = 1'b1; end
            S_MEMWRITE: begin AdrSrc = 1'b1; memw_s = 1'b1; end
            S_EXECUTER: alu_op_s = 1'b1;
            S_EXECUTEI: begin ALUSrcB = 2'b01; alu_op_s = 1'b1; end
            S_ALUWB:    regw_s = 1'b1;
            S_BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch_s = 1'b1; end
            default:    next_pc_s = 1'b0;
        endcase
    end

    // ALU command decode; unsupported commands fall back to ADD without writes
    always_comb begin
        alu_code_s  = 3'd0;
        supported_s = 1'b1;
        arith_s     = 1'b0;
        is_cmp_s    = 1'b0;
        case (cmd_s)
            4'b0100: begin alu_code_s = 3'd0; arith_s = 1'b1; end
            4'b0010: begin alu_code_s = 3'd1; arith_s = 1'b1; end
            4'b0000: alu_code_s = 3'd2;
            4'b1100: alu_code_s = 3'd3;
            4'b0001: alu_code_s = 3'd4;
            4'b1010: begin
                if (HAS_NOWRITE) begin
                    alu_code_s = 3'd1; arith_s = 1'b1; is_cmp_s = 1'b1;
                end else begin
                    supported_s = 1'b0;
                end
            end
            default: supported_s = 1'b0;
        endcase
    end

    // The no-write mask is taken from the held instruction so it still applies in ALUWB
    assign nowrite_s   = (op_s == 2'b00) & (is_cmp_s | ~supported_s);
    assign flag_w_s[1] = alu_op_s & funct_s[0] & supported_s;
    assign flag_w_s[0] = alu_op_s & funct_s[0] & supported_s & arith_s;
    assign ALUControl  = alu_op_s ? ALUCTRL_W'(alu_code_s) : {ALUCTRL_W{1'b0}};

    // ARM condition evaluation against the stored flags
    always_comb begin
        case (cond_s)
            4'b0000: condex_s = flag_z_s;
            4'b0001: condex_s = ~flag_z_s;
            4'b0010: condex_s = flag_c_s;
            4'b0011: condex_s = ~flag_c_s;
            4'b0100: condex_s = flag_n_s;
            4'b0101: condex_s = ~flag_n_s;
            4'b0110: condex_s = flag_v_s;
            4'b0111: condex_s = ~flag_v_s;
            4'b1000: condex_s = flag_c_s & ~flag_z_s;
            4'b1001: condex_s = ~flag_c_s | flag_z_s;
            4'b1010: condex_s = ~(flag_n_s ^ flag_v_s);
            4'b1011: condex_s = flag_n_s ^ flag_v_s;
            4'b1100: condex_s = ~flag_z_s & ~(flag_n_s ^ flag_v_s);
            4'b1101: condex_s = flag_z_s | (flag_n_s ^ flag_v_s);
            4'b1110: condex_s = 1'b1;
            default: condex_s = 1'b0;
        endcase
    end

    // Flag and condition register next values
    always_comb begin
        flags_d = flags_q;
        if (flag_w_s[1] & condexr_q) begin
            flags_d[3:2] = ALUFlags[3:2];
        end else begin
            flags_d[3:2] = flags_q[3:2];
        end
        if (flag_w_s[0] & condexr_q) begin
            flags_d[1:0] = ALUFlags[1:0];
        end else begin
            flags_d[1:0] = flags_q[1:0];
        end
        if (state_q == S_DECODE) begin
            condexr_d = condex_s;
        end else begin
            condexr_d = condexr_q;
        end
    end

    // State, flags and condition registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            flags_q   <= 4'b0000;
            condexr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            condexr_q <= condexr_d;
        end
    end

    // Write enables are also forced low directly by reset
    assign wb_state_s = (state_q == S_MEMWB) | (state_q == S_ALUWB) | (state_q == S_BRANCH);
    assign pcs_s      = branch_s | (regw_s & (rd_s == 4'b1111));
    assign RegWrite   = reset & regw_s & condexr_q & ~nowrite_s;
    assign MemWrite   = reset & memw_s & condexr_q;
    assign IRWrite    = reset & ir_s;
    assign PCWrite    = reset & (next_pc_s | (pcs_s & condexr_q & wb_state_s));
    assign ImmSrc     = op_s;
    assign RegSrc     = {op_s == 2'b01, op_s == 2'b10};
    assign State      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-cycle scoreboard of
// all outputs plus scenario-specific checks.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:12] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  ALUControl, State;

    multicycle_control_unit #(.ALUCTRL_W(4), .HAS_NOWRITE(1'b1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [3:0]  mdl_flags = 4'b0000;
    logic        mdl_cx = 1'b0;
    logic [21:0] exp_q[$];
    logic [3:0]  ob_st [8];
    logic        ob_pcw [8];
    logic        ob_adr [8];
    logic        ob_memw [8];
    logic        ob_ir [8];
    logic        ob_regw [8];
    logic [1:0]  ob_res [8];
    logic [3:0]  ob_aluc [8];
    int          ob_len;

    function automatic logic bench_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf & ~z;
            3'd5: r = (n == v);
            3'd6: r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'hF) r = 1'b0;
        else if (c[0] && c[3:1] != 3'd7) r = ~r;
        return r;
    endfunction

    function automatic logic [3:0] bench_next(input logic [3:0] st, input logic [31:12] ins);
        case (st)
            4'd0: return 4'd1;
            4'd1: begin
                if (ins[27:26] == 2'b01) return 4'd2;
                if (ins[27:26] == 2'b00) return ins[25] ? 4'd7 : 4'd6;
                if (ins[27:26] == 2'b10) return 4'd9;
                return 4'd0;
            end
            4'd2: return ins[20] ? 4'd3 : 4'd5;
            4'd3: return 4'd4;
            4'd6, 4'd7: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic bench_supported(input logic [3:0] cmd);
        return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 ||
               cmd == 4'b1100 || cmd == 4'b0001 || cmd == 4'b1010;
    endfunction

    function automatic logic [21:0] bench_exp(input logic [3:0] st, input logic [31:12] ins, input logic cx);
        logic pcw_n, adr, memw, ir, regw, br, aluop, srca, nw, pcs, pcw;
        logic [1:0] res, srcb, op;
        logic [3:0] cmd, aluc;
        {pcw_n, adr, memw, ir, regw, br, aluop, srca} = 8'b0;
        res = 2'b00; srcb = 2'b00;
        op = ins[27:26]; cmd = ins[24:21];
        case (st)
            4'd0: begin ir = 1'b1; pcw_n = 1'b1; srca = 1'b1; srcb = 2'b10; res = 2'b10; end
            4'd1: begin srca = 1'b1; srcb = 2'b10; res = 2'b10; end
            4'd2: srcb = 2'b01;
            4'd3: adr = 1'b1;
            4'd4: begin res = 2'b01; regw = 1'b1; end
            4'd5: begin adr = 1'b1; memw = 1'b1; end
            4'd6: aluop = 1'b1;
            4'd7: begin srcb = 2'b01; aluop = 1'b1; end
            4'd8: regw = 1'b1;
            4'd9: begin srcb = 2'b01; res = 2'b10; br = 1'b1; end
            default: ir = 1'b0;
        endcase
        aluc = 4'd0;
        if (aluop) begin
            if (cmd == 4'b0010 || cmd == 4'b1010) aluc = 4'd1;
            else if (cmd == 4'b0000) aluc = 4'd2;
            else if (cmd == 4'b1100) aluc = 4'd3;
            else if (cmd == 4'b0001) aluc = 4'd4;
        end
        nw  = (op == 2'b00) && (cmd == 4'b1010 || !bench_supported(cmd));
        pcs = br | (regw & (ins[15:12] == 4'hF));
        pcw = pcw_n | (pcs & cx & (st == 4'd4 || st == 4'd8 || st == 4'd9));
        return {st, pcw, adr, memw & cx, ir, regw & cx & ~nw, res, srca, srcb,
                op, op == 2'b01, op == 2'b10, aluc};
    endfunction

    function automatic int dut_len();
        int n = 1;
        for (int i = 1; i < ob_len; i++) if (ob_st[i] != 4'd0) n++;
        return n;
    endfunction

    // Runs one instruction from FETCH; abort_at >= 0 asserts reset after that cycle's sample
    task automatic run_instr(input logic [31:0] word, input logic [3:0] af, input int abort_at);
        logic [3:0]  st;
        logic [21:0] e, act;
        logic [31:12] ins;
        logic [3:0]  cmd;
        ins = word[31:12];
        cmd = ins[24:21];
        st = 4'd0;
        ob_len = 0;
        for (int i = 0; i < 8; i++) begin
            Instr = ins;
            ALUFlags = (st == 4'd6 || st == 4'd7) ? af : ~af;
            exp_q.push_back(bench_exp(st, ins, mdl_cx));
            @(negedge clk);
            act = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                   ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};
            ob_st[i] = State; ob_pcw[i] = PCWrite; ob_adr[i] = AdrSrc; ob_memw[i] = MemWrite;
            ob_ir[i] = IRWrite; ob_regw[i] = RegWrite; ob_res[i] = ResultSrc; ob_aluc[i] = ALUControl;
            ob_len = i + 1;
            e = exp_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL cycle%0d instr=%h: got %h want %h", i, word, act, e);
            end
            if (i == abort_at) begin
                #1 reset = 1'b0;
                #1;
                return;
            end
            @(posedge clk);
            if (st == 4'd1) mdl_cx = bench_cond(ins[31:28], mdl_flags);
            if ((st == 4'd6 || st == 4'd7) && ins[27:26] == 2'b00 && ins[20] &&
                bench_supported(cmd) && mdl_cx) begin
                mdl_flags[3:2] = af[3:2];
                if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) mdl_flags[1:0] = af[1:0];
            end
            st = bench_next(st, ins);
            #1;
            if (st == 4'd0) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (State !== 4'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got st=%0d mw=%b rw=%b want 0 0 0", State, MemWrite, RegWrite);
        end
        total++;
        if ({ALUSrcA, ALUSrcB, ResultSrc, AdrSrc} !== 6'b1_10_10_0) begin
            bad++;
            $display("FAIL reset_selects: got %b want 110100", {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc});
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_mov_unsupported();
        run_instr(32'hE3A01005, 4'b0000, -1);
        total++;
        if (dut_len() !== 4) begin bad++; $display("FAIL mov_len: got %0d want 4", dut_len()); end
        total++;
        if ({ob_ir[0], ob_ir[1], ob_ir[2], ob_ir[3]} !== 4'b1000) begin
            bad++; $display("FAIL mov_irwrite: got %b want 1000", {ob_ir[0], ob_ir[1], ob_ir[2], ob_ir[3]});
        end
        total++;
        if ({ob_regw[0], ob_regw[1], ob_regw[2], ob_regw[3]} !== 4'b0000) begin
            bad++; $display("FAIL mov_regwrite: got %b want 0000", {ob_regw[0], ob_regw[1], ob_regw[2], ob_regw[3]});
        end
    endtask

    task automatic test_adds();
        run_instr(32'hE0910002, 4'b0110, -1);
        total++;
        if (ob_st[2] !== 4'd6 || ob_aluc[2] !== 4'd0 || ob_regw[3] !== 1'b1) begin
            bad++; $display("FAIL adds_exec: got st=%0d aluc=%0d rw=%b want 6 0 1", ob_st[2], ob_aluc[2], ob_regw[3]);
        end
        run_instr(32'h0A000001, 4'b0000, -1);
        total++;
        if (ob_pcw[2] !== 1'b1) begin bad++; $display("FAIL adds_beq: got pcw=%b want 1", ob_pcw[2]); end
        run_instr(32'h4A000001, 4'b0000, -1);
        total++;
        if (ob_pcw[2] !== 1'b0) begin bad++; $display("FAIL adds_bmi: got pcw=%b want 0", ob_pcw[2]); end
        run_instr(32'h2A000001, 4'b0000, -1);
        total++;
        if (ob_pcw[2] !== 1'b1) begin bad++; $display("FAIL adds_bcs: got pcw=%b want 1", ob_pcw[2]); end
    endtask

    task automatic test_beq_not_taken();
        run_instr(32'hE0910002, 4'b0000, -1);
        run_instr(32'h0A000001, 4'b0000, -1);
        total++;
        if (ob_st[2] !== 4'd9 || ob_pcw[2] !== 1'b0) begin
            bad++; $display("FAIL beq_nt: got st=%0d pcw=%b want 9 0", ob_st[2], ob_pcw[2]);
        end
        run_instr(32'hEC000000, 4'b0000, -1);
        total++;
        if (ob_st[0] !== 4'd0 || dut_len() !== 2) begin
            bad++; $display("FAIL nop_after_branch: got st0=%0d len=%0d want 0 2", ob_st[0], dut_len());
        end
    endtask

    task automatic test_back_to_back();
        int len_cmp;
        logic any_rw;
        run_instr(32'hE3500000, 4'b0100, -1);
        len_cmp = dut_len();
        any_rw = 1'b0;
        for (int i = 0; i < ob_len; i++) any_rw = any_rw | ob_regw[i];
        total++;
        if (any_rw !== 1'b0) begin bad++; $display("FAIL cmp_regwrite: got %b want 0", any_rw); end
        run_instr(32'h0A000001, 4'b0000, -1);
        total++;
        if (ob_pcw[2] !== 1'b1) begin bad++; $display("FAIL cmp_beq_taken: got pcw=%b want 1", ob_pcw[2]); end
        total++;
        if (len_cmp + dut_len() !== 7) begin
            bad++; $display("FAIL cmp_beq_len: got %0d want 7", len_cmp + dut_len());
        end
    endtask

    task automatic test_ldr_str();
        run_instr(32'hE5910000, 4'b0000, -1);
        total++;
        if (dut_len() !== 5 || ob_adr[3] !== 1'b1) begin
            bad++; $display("FAIL ldr_len_adr: got len=%0d adr=%b want 5 1", dut_len(), ob_adr[3]);
        end
        total++;
        if (ob_res[4] !== 2'b01 || ob_regw[4] !== 1'b1) begin
            bad++; $display("FAIL ldr_wb: got res=%b rw=%b want 01 1", ob_res[4], ob_regw[4]);
        end
        run_instr(32'hE5810000, 4'b0000, -1);
        total++;
        if (dut_len() !== 4 || {ob_memw[0], ob_memw[1], ob_memw[2], ob_memw[3]} !== 4'b0001) begin
            bad++; $display("FAIL str_memwrite: got len=%0d mw=%b want 4 0001", dut_len(),
                            {ob_memw[0], ob_memw[1], ob_memw[2], ob_memw[3]});
        end
        run_instr(32'h15810000, 4'b0000, -1);
        total++;
        if ({ob_memw[0], ob_memw[1], ob_memw[2], ob_memw[3]} !== 4'b0000) begin
            bad++; $display("FAIL strne_suppressed: got %b want 0000", {ob_memw[0], ob_memw[1], ob_memw[2], ob_memw[3]});
        end
    endtask

    task automatic test_reset_mid();
        run_instr(32'hE0910002, 4'b1111, -1);
        run_instr(32'hE5810000, 4'b0000, 3);
        total++;
        if (MemWrite !== 1'b0 || State !== 4'd0 || RegWrite !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got mw=%b st=%0d rw=%b want 0 0 0", MemWrite, State, RegWrite);
        end
        mdl_flags = 4'b0000;
        mdl_cx = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        run_instr(32'h0A000001, 4'b0000, -1);
        total++;
        if (ob_pcw[2] !== 1'b0) begin bad++; $display("FAIL reset_flags_z: got pcw=%b want 0", ob_pcw[2]); end
        run_instr(32'h3A000001, 4'b0000, -1);
        total++;
        if (ob_pcw[2] !== 1'b1) begin bad++; $display("FAIL reset_flags_c: got pcw=%b want 1", ob_pcw[2]); end
    endtask

    initial begin
        reset = 1'b0;
        Instr = 20'h00000;
        ALUFlags = 4'b0000;
        repeat (2) @(posedge clk);
        test_reset();
        test_mov_unsupported();
        test_adds();
        test_beq_not_taken();
        test_back_to_back();
        test_ldr_str();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Control unit for the multicycle ARM-subset datapath. It replaces the single-cycle decoder/condition-logic pair with a Moore main FSM, an ALU decoder, an NZCV flag register and registered condition evaluation. The block drives PC/IR write enables, memory/register write enables and all datapath mux selects, one FSM state per clock. The ALU control width and the compare (no-write) capability are parametrised.

Parameters:
ALUCTRL_W, 4, width of ALUControl; must be >= 3.
HAS_NOWRITE, 1, 1: CMP (cmd 1010, S=1) updates flags without a register write; 0: cmd 1010 decodes as unsupported.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Instr  input  20  Instr[31:12] from the instruction register
ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
PCWrite  output  1  PC register load enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register load enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU
ALUSrcA  output  1  0 = register A, 1 = PC
ALUSrcB  output  2  00 = register B, 01 = ExtImm, 10 = constant 4
ImmSrc  output  2  equal to Instr[27:26]
RegSrc  output  2  [0] = (Op==10), [1] = (Op==01)
ALUControl  output  ALUCTRL_W  ALU operation, zero-extended code
State  output  4  current FSM state (debug)

Behaviour:
- Reset (reset=0, async): State=FETCH, Flags=0000, CondExR=0. All outputs take their FETCH-state values combinationally.
- Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12], Cond=Instr[31:28].
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9. Unused encodings go to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (NOP).
  - MEMADR: Funct[0]=1 -> MEMREAD, otherwise MEMWRITE.
  - MEMREAD -> MEMWB. EXECUTER/EXECUTEI -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH -> FETCH.
- Instruction latency: LDR 5 cycles, STR 4, data-processing 4, B 3, Op=11 2.
- Per-state outputs (unlisted controls are 0; unlisted selects hold their defaults AdrSrc=0, ALUSrcA=0, ALUSrcB=00, ResultSrc=00):
  - FETCH: IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 -> ADD.
  - Otherwise, by Funct[4:1]: 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3, 0001 EOR=4, 1010 CMP=1 (only when HAS_NOWRITE=1).
  - Any other cmd -> ADD, with FlagW=00 and RegW suppressed.
- FlagW[1] (NZ) = ALUOp & S. FlagW[0] (CV) = ALUOp & S & (op is ADD/SUB/CMP).
- NoWrite=1 for CMP; NoWrite masks RegWrite in ALUWB.
- Condition evaluation:
  - CondEx is combinational from Cond and the stored Flags, using ARM codes 0000–1110. Cond=1111 -> 0.
  - CondExR is loaded on the DECODE->next edge and held until the next DECODE.
- Gating:
  - RegWrite = RegW & CondExR & ~NoWrite.
  - MemWrite = MemW & CondExR.
  - PCS = Branch | (RegW & Rd==1111).
  - PCWrite = NextPC | (PCS & CondExR & state is MEMWB, ALUWB or BRANCH).
- Flags update at the end of EXECUTER/EXECUTEI only:
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1] & CondExR.
  - Flags[1:0] <= ALUFlags[1:0] if FlagW[0] & CondExR.
- Back-to-back instructions: a flag write in instruction k is visible to the CondEx of instruction k+1 (it is registered before k+1's DECODE).
- Reset asserted mid-instruction: state, flags and CondExR clear immediately; no write enable may be high while reset=0.

Test Plan:
- Reset release, then fetch of E3A01005 (MOV-class, cmd 1101 unsupported) -> FETCH, DECODE, EXECUTEI, ALUWB, FETCH; IRWrite=1 in cycle 0 only; RegWrite stays 0.
- E0910002 (ADDS R0,R1,R2) with ALUFlags=0110 -> ALUControl=0 in EXECUTER; RegWrite=1 in ALUWB; stored Flags=0110.
- E3500000 (CMP R0,#0) with ALUFlags=0100, then 0A000001 (BEQ) -> BEQ sees CondExR=1; PCWrite=1 in BRANCH; RegWrite=0 during CMP; total 7 cycles.
- With Flags Z=0, 0A000001 -> BRANCH state entered but PCWrite=0 in it; next instruction begins in FETCH.
- E5910000 (LDR) -> 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01 with RegWrite=1 in MEMWB. E5810000 (STR) -> MemWrite=1 only in MEMWRITE.
- Drive reset=0 during MEMWRITE -> MemWrite drops within the same cycle; State=0 and Flags=0000.
